// File: rtl/debug_uart_rx.sv
// ----------------------------------------------------------------------------
// debug_uart_rx
// Receive-only 8N1 UART for a debug console. Samples an asynchronous serial
// line, rebuilds bytes LSB first and hands them to a consumer through a
// single-entry valid/ack holding register. It also keeps two sticky error
// flags: overrun and framing.
//
// Parameters
//   CLK_HZ        system clock frequency in Hz
//   BIT_RATE      serial bit rate in bit/s
//
// Ports
//   clk           single clock, all state updates on the rising edge
//   rst           asynchronous active-high reset
//   uart_rxd      asynchronous serial input, idle high
//   rx_ack        one-cycle pulse, the consumer has read rx_data
//   err_clr       one-cycle pulse, clears both sticky error flags
//   rx_data       last accepted byte
//   rx_valid      rx_data holds a byte that has not been read yet
//   rx_busy       a frame is being received (receiver not idle)
//   rx_overrun    sticky, a byte was lost because rx_valid was still set
//   rx_frame_err  sticky, a stop bit was sampled low
// ----------------------------------------------------------------------------
module debug_uart_rx #(
    parameter int CLK_HZ   = 64_000_000,
    parameter int BIT_RATE = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rxd,
    input  logic       rx_ack,
    input  logic       err_clr,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       rx_overrun,
    output logic       rx_frame_err
);

    localparam int CPB  = CLK_HZ / BIT_RATE;
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB) + 1;

    // Terminal counts. Every wait counts from zero, so "N cycles" ends at N-1.
    // If HALF is zero, the start bit is sampled on the first START cycle.
    localparam logic [CW-1:0] CPB_LAST  = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'((HALF > 0) ? (HALF - 1) : 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t        state_q, state_d;
    logic          syncMeta_q;
    logic          rxdS_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bitIdx_q, bitIdx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          overrun_q, overrun_d;
    logic          frameErr_q, frameErr_d;
    logic          accept;

    // Two-flop synchronizer on the raw line. Both flops reset to the idle
    // level, so a reset never produces a false start bit. rxdS_q is the
    // synchronized line value, and all frame decoding uses it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            syncMeta_q <= 1'b1;
            rxdS_q     <= 1'b1;
        end else begin
            syncMeta_q <= uart_rxd;
            rxdS_q     <= syncMeta_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bitIdx_q   <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
            frameErr_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bitIdx_q   <= bitIdx_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
            frameErr_q <= frameErr_d;
        end
    end

    // Next-state and datapath logic.
    // err_clr is applied first, and error events are ORed in afterwards.
    // This way an error in the same cycle as a clear still leaves its flag set.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bitIdx_d   = bitIdx_q;
        shift_d    = shift_q;
        data_d     = data_q;
        valid_d    = valid_q;
        overrun_d  = overrun_q & ~err_clr;
        frameErr_d = frameErr_q & ~err_clr;
        accept     = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rxdS_q) begin
                    state_d = START;
                end
            end

            // Check the start bit again at its midpoint.
            // A line that is already high again was a glitch: drop it silently.
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d    = '0;
                    bitIdx_d = '0;
                    state_d  = rxdS_q ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // One sample per bit period. Each sample enters at the MSB end,
            // so the first bit received ends up at the LSB after 8 shifts.
            DATA: begin
                if (cnt_q == CPB_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rxdS_q, shift_q[7:1]};
                    if (bitIdx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bitIdx_d = bitIdx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            STOP: begin
                if (cnt_q == CPB_LAST) begin
                    cnt_d = '0;
                    if (rxdS_q) begin
                        accept  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        frameErr_d = 1'b1;
                        state_d    = BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // Stay here for as long as the line is held low.
            // A long break therefore reports exactly one framing error.
            BREAK: begin
                cnt_d = '0;
                if (rxdS_q) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Holding register. An ack in the acceptance cycle frees the slot,
        // so the new byte is taken and rx_valid stays high.
        if (accept) begin
            if (!valid_q || rx_ack) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rx_ack) begin
            valid_d = 1'b0;
        end
    end

    assign rx_data      = data_q;
    assign rx_valid     = valid_q;
    assign rx_overrun   = overrun_q;
    assign rx_frame_err = frameErr_q;
    assign rx_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_debug_uart_rx.sv
// ----------------------------------------------------------------------------
// tb_debug_uart_rx
// Self-checking bench for debug_uart_rx at CLK_HZ=16, BIT_RATE=1
// (16 clocks per bit). A byte-level reference model holds the expected
// consumer-visible state. The model applies the receiver's rules once per
// whole frame, ack pulse or clear pulse.
// ----------------------------------------------------------------------------
module tb_debug_uart_rx;

    localparam int CLK_HZ   = 16;
    localparam int BIT_RATE = 1;
    localparam int CPB      = CLK_HZ / BIT_RATE;
    localparam int HALF     = CPB / 2;
    // Clocks from the falling edge of the start bit to rx_valid rising.
    localparam int LAT      = 2 + HALF + 9 * CPB + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       uart_rxd;
    logic       rx_ack;
    logic       err_clr;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       rx_overrun;
    logic       rx_frame_err;

    int checks = 0;
    int errors = 0;

    // Reference model of what the consumer should see.
    logic [7:0] mData;
    logic       mValid;
    logic       mOverrun;
    logic       mFrameErr;

    debug_uart_rx #(
        .CLK_HZ   (CLK_HZ),
        .BIT_RATE (BIT_RATE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .uart_rxd     (uart_rxd),
        .rx_ack       (rx_ack),
        .err_clr      (err_clr),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_busy      (rx_busy),
        .rx_overrun   (rx_overrun),
        .rx_frame_err (rx_frame_err)
    );

    always #5 clk = ~clk;

    // Stop the run if it hangs.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, "_data"},     32'(rx_data),      32'(mData));
        checkOutput({tag, "_valid"},    32'(rx_valid),     32'(mValid));
        checkOutput({tag, "_overrun"},  32'(rx_overrun),   32'(mOverrun));
        checkOutput({tag, "_frameErr"}, 32'(rx_frame_err), 32'(mFrameErr));
    endtask

    // Model rules for one complete frame.
    task automatic modelFrame(input logic [7:0] b, input logic stopOk, input logic ackSame);
        if (!stopOk) begin
            mFrameErr = 1'b1;
        end else if (!mValid || ackSame) begin
            mData  = b;
            mValid = 1'b1;
        end else begin
            mOverrun = 1'b1;
        end
    endtask

    task automatic modelReset();
        mData     = 8'h00;
        mValid    = 1'b0;
        mOverrun  = 1'b0;
        mFrameErr = 1'b0;
    endtask

    // Every stimulus task starts and ends 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulseAck();
        rx_ack = 1'b1;
        idle(1);
        rx_ack = 1'b0;
        mValid = 1'b0;
    endtask

    task automatic pulseErrClr();
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        mOverrun  = 1'b0;
        mFrameErr = 1'b0;
    endtask

    // Drive one 8N1 frame. If the stop bit is 0, the line stays low afterwards.
    // A nonzero ackAt pulses rx_ack on the clock ackAt cycles after the start edge.
    task automatic applyStimulus(input logic [7:0] b, input logic stopBit, input int ackAt);
        fork
            begin
                uart_rxd = 1'b0;
                idle(CPB);
                for (int i = 0; i < 8; i++) begin
                    uart_rxd = b[i];
                    idle(CPB);
                end
                uart_rxd = stopBit;
                idle(CPB);
            end
            begin
                if (ackAt > 0) begin
                    idle(ackAt - 1);
                    rx_ack = 1'b1;
                    idle(1);
                    rx_ack = 1'b0;
                end
            end
        join
    endtask

    initial begin
        int         cyc;
        logic [7:0] rb;
        logic       rStopOk;

        rst      = 1'b1;
        uart_rxd = 1'b1;
        rx_ack   = 1'b0;
        err_clr  = 1'b0;
        modelReset();
        idle(3);
        checkAll("reset");
        checkOutput("reset_busy", 32'(rx_busy), 32'd0);
        rst = 1'b0;
        idle(4);

        // Single byte: check the data and the latency window.
        cyc = 0;
        fork
            applyStimulus(8'hA5, 1'b1, 0);
            begin
                while (!rx_valid && cyc < 300) begin
                    idle(1);
                    cyc++;
                end
            end
        join
        checkOutput("a5_latency_window", 32'((cyc >= LAT - 1) && (cyc <= LAT + 1)), 32'd1);
        modelFrame(8'hA5, 1'b1, 1'b0);
        checkAll("a5");
        checkOutput("a5_busy", 32'(rx_busy), 32'd0);

        // Overrun with back-to-back frames, then clear the sticky flag.
        pulseAck();
        applyStimulus(8'h3C, 1'b1, 0);
        modelFrame(8'h3C, 1'b1, 1'b0);
        applyStimulus(8'hC3, 1'b1, 0);
        modelFrame(8'hC3, 1'b1, 1'b0);
        checkAll("overrun");
        pulseErrClr();
        checkAll("overrun_clr");

        // Ack in the exact acceptance cycle of the second byte.
        pulseAck();
        applyStimulus(8'h55, 1'b1, 0);
        modelFrame(8'h55, 1'b1, 1'b0);
        applyStimulus(8'hAA, 1'b1, LAT);
        modelFrame(8'hAA, 1'b1, 1'b1);
        checkAll("ack_same_cycle");

        // Short low glitch on the idle line.
        pulseAck();
        uart_rxd = 1'b0;
        idle(4);
        checkOutput("glitch_busy", 32'(rx_busy), 32'd1);
        uart_rxd = 1'b1;
        idle(CPB);
        checkOutput("glitch_idle", 32'(rx_busy), 32'd0);
        checkAll("glitch");
        applyStimulus(8'h01, 1'b1, 0);
        modelFrame(8'h01, 1'b1, 1'b0);
        checkAll("after_glitch");

        // Framing error followed by a long break; the break sets no second error.
        pulseAck();
        applyStimulus(8'h00, 1'b0, 0);
        modelFrame(8'h00, 1'b0, 1'b0);
        idle(40);
        checkOutput("break_busy", 32'(rx_busy), 32'd1);
        checkAll("frame_err");
        pulseErrClr();
        idle(5);
        checkAll("break_cleared");
        uart_rxd = 1'b1;
        idle(4);
        checkOutput("break_exit", 32'(rx_busy), 32'd0);
        checkAll("break_exit");
        applyStimulus(8'h7E, 1'b1, 0);
        modelFrame(8'h7E, 1'b1, 1'b0);
        checkAll("after_break");

        // Reset in the middle of data bit 4 of 0xFF.
        uart_rxd = 1'b0;
        idle(CPB);
        for (int i = 0; i < 4; i++) begin
            uart_rxd = 1'b1;
            idle(CPB);
        end
        idle(HALF);
        checkOutput("pre_reset_busy", 32'(rx_busy), 32'd1);
        rst = 1'b1;
        #1;
        modelReset();
        checkAll("mid_reset");
        checkOutput("mid_reset_busy", 32'(rx_busy), 32'd0);
        idle(3);
        rst = 1'b0;
        idle(CPB);
        checkAll("post_reset");
        applyStimulus(8'h81, 1'b1, 0);
        modelFrame(8'h81, 1'b1, 1'b0);
        checkAll("after_reset");

        // Random frames with random acks, clears, glitches and bad stop bits.
        for (int n = 0; n < 16; n++) begin
            rb      = 8'($urandom);
            rStopOk = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 1) == 1) pulseAck();
            if ($urandom_range(0, 3) == 0) pulseErrClr();
            if ($urandom_range(0, 3) == 0) begin
                uart_rxd = 1'b0;
                idle($urandom_range(1, HALF - 2));
                uart_rxd = 1'b1;
                idle(CPB);
            end
            applyStimulus(rb, rStopOk, 0);
            if (!rStopOk) begin
                idle($urandom_range(0, 40));
                uart_rxd = 1'b1;
                idle(4);
            end
            modelFrame(rb, rStopOk, 1'b0);
            checkAll("rand");
            checkOutput("rand_busy", 32'(rx_busy), 32'd0);
            idle($urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/debug_uart_rx.md
DEBUG_UART_RX -- requirements
Module: debug_uart_rx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 64_000_000, meaning system clock frequency in Hz.
REQ-002 SHALL have parameter BIT_RATE, default 9600, meaning serial bit rate in bit/s.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port uart_rxd  input  1  asynchronous serial line, idle high.
REQ-006 SHALL have port rx_ack  input  1  one-cycle pulse, consumer has read rx_data.
REQ-007 SHALL have port err_clr  input  1  one-cycle pulse, clears sticky error flags.
REQ-008 SHALL have port rx_data  output  8  last accepted byte.
REQ-009 SHALL have port rx_valid  output  1  rx_data holds an unread byte.
REQ-010 SHALL have port rx_busy  output  1  frame reception in progress (state != IDLE).
REQ-011 SHALL have port rx_overrun  output  1  sticky; byte lost because rx_valid was still set.
REQ-012 SHALL have port rx_frame_err  output  1  sticky; stop bit sampled low.

Function
REQ-013 SHALL pass uart_rxd through a 2-flop synchronizer, reset value 1; all decoding uses the synchronized value rxd_s.
REQ-014 SHALL define CPB = CLK_HZ/BIT_RATE (integer division) and HALF = CPB/2; bit counter width SHALL be $clog2(CPB)+1.
REQ-015 SHALL frame 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1); no parity.
REQ-016 SHALL implement states IDLE, START, DATA, STOP, BREAK.
REQ-017 IDLE: on rxd_s == 0 SHALL enter START with counter cleared.
REQ-018 START: after HALF cycles SHALL sample rxd_s; 0 -> DATA, counter cleared; 1 -> IDLE (glitch rejected, no flags changed).
REQ-019 DATA: SHALL sample rxd_s every CPB cycles into a shift register, LSB first; after the 8th sample -> STOP.
REQ-020 STOP: after CPB cycles SHALL sample rxd_s; 1 -> byte accepted (REQ-021), go IDLE; 0 -> set rx_frame_err, discard byte, go BREAK.
REQ-021 Byte accepted: if rx_valid == 0 or rx_ack asserted that cycle, rx_data SHALL load the byte and rx_valid SHALL be 1 next cycle; else rx_data SHALL retain old byte, new byte discarded, rx_overrun set.
REQ-022 BREAK: SHALL wait for rxd_s == 1, then IDLE; low line of any duration SHALL produce at most one frame error.
REQ-023 rx_ack with no acceptance that cycle SHALL clear rx_valid next cycle; rx_ack while rx_valid == 0 SHALL have no effect.
REQ-024 err_clr SHALL clear both sticky flags next cycle; an error event in the same cycle as err_clr SHALL win (flag stays set).
REQ-025 Latency: rx_valid SHALL rise on the clock after the stop-bit sample, i.e. 2 + HALF + 9*CPB + 1 cycles (+/-1) after uart_rxd falling edge.
REQ-026 rx_busy SHALL be combinational from state (high in START, DATA, STOP, BREAK).
REQ-027 Reception SHALL continue independently of rx_valid; back-to-back frames with no idle gap SHALL be received.

Reset
REQ-028 rst SHALL asynchronously force: state IDLE, synchronizer flops 1, counters 0, shift register 0, rx_data 0x00, rx_valid 0, rx_overrun 0, rx_frame_err 0.
REQ-029 rst asserted mid-frame SHALL abort the frame with no flag or data update; after release a line still low SHALL be treated as a new start bit.

Verification (CLK_HZ=16, BIT_RATE=1, CPB=16, HALF=8)
REQ-030 Send 0xA5 with valid stop -> rx_data=0xA5, rx_valid=1 at cycle 2+8+144+1 (+/-1), both error flags 0.
REQ-031 Send 0x3C, no ack, then 0xC3 -> rx_data stays 0x3C, rx_overrun=1; pulse err_clr -> rx_overrun=0, rx_valid still 1.
REQ-032 Send 0x55 then 0xAA with rx_ack pulsed in the exact cycle 0xAA is accepted -> rx_data=0xAA, rx_valid=1, rx_overrun=0.
REQ-033 Low glitch of 4 cycles on idle line -> returns to IDLE, rx_valid=0, no flags; following byte 0x01 received correctly.
REQ-034 Frame 0x00 with stop bit low, line held low 40 cycles -> rx_frame_err=1, rx_valid=0, single BREAK exit on line high; next byte 0x7E received.
REQ-035 Assert rst during DATA bit 4 of 0xFF -> all outputs 0 immediately; after release with line high, byte 0x81 received correctly.
